// File: rtl/grant_mux.sv
// Packet-locking N:1 beat mux steered by an external round-robin grant; 1-cycle registered output.
// Backpressure: ack is withheld unless the output register is empty or draining this cycle.
module grant_mux #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data,
  input  logic [N-1:0]   last,
  input  logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [IW-1:0]  out_src,
  input  logic           out_ready,
  output logic           locked,
  output logic           grant_err
);

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [W-1:0]  dat;
    logic          last;
    logic [IW-1:0] src;
  } beat_t;

  state_t        state;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] grant_idx;
  logic          grant_vld;
  logic [IW-1:0] sel;
  logic          sel_vld;
  logic          sel_req;
  beat_t         sel_beat;
  logic          space;
  logic          xfer;
  logic          multi_grant;

  assign space       = !out_valid || out_ready;
  assign multi_grant = |(grant & (grant - N'(1)));
  assign locked      = (state == LOCKED);

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    // Descending scan so the lowest set grant bit wins when several are set.
    for (int i = N - 1; i >= 0; i--) begin
      if (grant[i]) begin
        grant_idx = IW'(i);
        grant_vld = 1'b1;
      end
    end

    if (state == LOCKED) begin
      sel     = lock_idx;
      sel_vld = 1'b1;
    end else begin
      sel     = grant_idx;
      sel_vld = grant_vld;
    end

    sel_req       = 1'b0;
    sel_beat.dat  = '0;
    sel_beat.last = 1'b0;
    sel_beat.src  = sel;
    for (int i = 0; i < N; i++) begin
      ack[i] = space && rst && sel_vld && (IW'(i) == sel);
      if (IW'(i) == sel) begin
        sel_req       = req[i];
        sel_beat.dat  = data[i*W +: W];
        sel_beat.last = last[i];
      end
    end

    xfer = sel_vld && sel_req && space && rst;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lock_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
      grant_err <= 1'b0;
    end else begin
      if (multi_grant) begin
        grant_err <= 1'b1;
      end
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_beat.dat;
        out_last  <= sel_beat.last;
        out_src   <= sel_beat.src;
        if (state == IDLE && !sel_beat.last) begin
          state    <= LOCKED;
          lock_idx <= sel;
        end else if (state == LOCKED && sel_beat.last) begin
          state <= IDLE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grant_mux.sv
// Self-checking bench for grant_mux: directed scenarios plus an output-beat scoreboard.
module tb_grant_mux;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   last;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [IW-1:0]  out_src;
  logic           out_ready;
  logic           locked;
  logic           grant_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          l;
    logic [IW-1:0] s;
  } beat_t;
  beat_t sb[$];

  grant_mux #(.N(N), .W(W), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .last(last), .grant(grant),
    .ack(ack), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready), .locked(locked), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  // Output transfers are popped before this cycle's input acceptances are pushed.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        beat_t got, exp;
        got = '{d: out_data, l: out_last, s: out_src};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got d=%h l=%b s=%0d, required no beat", got.d, got.l, got.s);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL sb_beat: got d=%h l=%b s=%0d, required d=%h l=%b s=%0d",
                     got.d, got.l, got.s, exp.d, exp.l, exp.s);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) sb.push_back('{d: data[i*W +: W], l: last[i], s: IW'(i)});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req = '0; grant = '0; last = '0; data = '0; out_ready = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b0;
    req = 5'b00100; grant = 5'b00100;
    #2;
    checks++;
    if (ack !== 5'b0) begin errors++; $display("FAIL reset_ack: got %b, required 00000", ack); end
    tick();
    tick();
    checks++;
    if ({out_valid, locked, grant_err, out_last, out_data, out_src} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b lk=%b ge=%b l=%b d=%h s=%0d, required all zero",
               out_valid, locked, grant_err, out_last, out_data, out_src);
    end
    rst = 1'b1;
    idle_inputs();
    sb.delete();
    tick();
  endtask

  task automatic test_single_beat;
    req = 5'b00100; grant = 5'b00100; last = 5'b00100; data[2*W +: W] = 8'hA5; out_ready = 1'b1;
    #2;
    checks++;
    if (ack !== 5'b00100) begin errors++; $display("FAIL single_ack: got %b, required 00100", ack); end
    tick();
    checks++;
    if (!(out_valid === 1'b1 && out_data === 8'hA5 && out_src === 3'd2 && out_last === 1'b1 && locked === 1'b0)) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h s=%0d l=%b lk=%b, required v=1 d=a5 s=2 l=1 lk=0",
               out_valid, out_data, out_src, out_last, locked);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_packet_lock;
    for (int b = 0; b < 3; b++) begin
      req = 5'b00011;
      grant = (b == 0) ? 5'b00010 : 5'b00001;
      last = (b == 2) ? 5'b00011 : 5'b00001;
      data[0 +: W] = 8'h0F;
      data[W +: W] = 8'h10 + 8'(b);
      #2;
      checks++;
      if (ack !== 5'b00010) begin errors++; $display("FAIL lock_ack%0d: got %b, required 00010", b, ack); end
      tick();
      checks++;
      if (locked !== (b != 2)) begin
        errors++; $display("FAIL lock_state%0d: got %b, required %b", b, locked, (b != 2));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure;
    req = 5'b01000; grant = 5'b01000; last = 5'b01000; data[3*W +: W] = 8'h31; out_ready = 1'b0;
    #2;
    checks++;
    if (ack !== 5'b01000) begin errors++; $display("FAIL bp_first_ack: got %b, required 01000", ack); end
    tick();
    data[3*W +: W] = 8'h32;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (ack !== 5'b0) begin errors++; $display("FAIL bp_stall_ack%0d: got %b, required 00000", c, ack); end
      tick();
      checks++;
      if (!(out_valid === 1'b1 && out_data === 8'h31 && out_src === 3'd3)) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d, required v=1 d=31 s=3", c, out_valid, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    #2;
    checks++;
    if (ack !== 5'b01000) begin errors++; $display("FAIL bp_resume_ack: got %b, required 01000", ack); end
    tick();
    checks++;
    if (!(out_valid === 1'b1 && out_data === 8'h32)) begin
      errors++; $display("FAIL bp_no_bubble: got v=%b d=%h, required v=1 d=32", out_valid, out_data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_illegal_grant;
    req = 5'b01010; grant = 5'b01010; last = 5'b01010;
    data[W +: W] = 8'h11; data[3*W +: W] = 8'h33;
    #2;
    checks++;
    if (ack !== 5'b00010) begin errors++; $display("FAIL illegal_ack: got %b, required 00010", ack); end
    tick();
    checks++;
    if (!(out_src === 3'd1 && out_data === 8'h11)) begin
      errors++; $display("FAIL illegal_src: got s=%0d d=%h, required s=1 d=11", out_src, out_data);
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (grant_err !== 1'b1) begin errors++; $display("FAIL illegal_sticky%0d: got %b, required 1", c, grant_err); end
      tick();
    end
  endtask

  task automatic test_mid_reset;
    for (int b = 0; b < 2; b++) begin
      req = 5'b00100; grant = (b == 0) ? 5'b00100 : 5'b00000; last = 5'b0;
      data[2*W +: W] = 8'h20 + 8'(b);
      tick();
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL midrst_locked: got %b, required 1", locked); end
    rst = 1'b0;
    grant = 5'b00100;
    #2;
    checks++;
    if (ack !== 5'b0) begin errors++; $display("FAIL midrst_ack: got %b, required 00000", ack); end
    tick();
    sb.delete();
    checks++;
    if (!(out_valid === 1'b0 && locked === 1'b0 && grant_err === 1'b0)) begin
      errors++; $display("FAIL midrst_state: got v=%b lk=%b ge=%b, required 0 0 0", out_valid, locked, grant_err);
    end
    rst = 1'b1;
    req = 5'b10100; grant = 5'b10000; last = 5'b10000; data[4*W +: W] = 8'h44;
    #2;
    checks++;
    if (ack !== 5'b10000) begin errors++; $display("FAIL midrst_regrant: got %b, required 10000", ack); end
    tick();
    checks++;
    if (!(out_valid === 1'b1 && out_src === 3'd4)) begin
      errors++; $display("FAIL midrst_out: got v=%b s=%0d, required v=1 s=4", out_valid, out_src);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin;
    int ptr;
    int exp_src;
    logic [N-1:0] bc;
    ptr = 0;
    bc = '0;
    for (int k = 0; k < 20; k++) begin
      exp_src = (k / 2) % N;
      req = '1;
      grant = N'(1) << ptr;
      last = bc;
      for (int i = 0; i < N; i++) data[i*W +: W] = 8'(i * 16 + k);
      out_ready = 1'b1;
      #2;
      checks++;
      if (ack !== (N'(1) << exp_src)) begin
        errors++; $display("FAIL rr_ack%0d: got %b, required one-hot %0d", k, ack, exp_src);
      end
      if (bc[exp_src]) ptr = (exp_src + 1) % N;
      bc[exp_src] = ~bc[exp_src];
      tick();
      checks++;
      if (!(out_valid === 1'b1 && out_src === IW'(exp_src))) begin
        errors++; $display("FAIL rr_out%0d: got v=%b s=%0d, required v=1 s=%0d", k, out_valid, out_src, exp_src);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_illegal_grant();
    test_mid_reset();
    test_round_robin();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d beats outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grant_mux.md
GRANT_MUX -- requirements
Module: grant_mux

Interface
REQ-001 Parameter N, default 5, number of sources; SHALL be 2..16.
REQ-002 Parameter W, default 8, data width per source, in bits.
REQ-003 Parameter IW, default $clog2(N), width of the source index.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-low: state resets on a clk rising edge while rst==0.
REQ-006 req  in  N  per-source beat valid; also drives the round-robin arbiter's request input.
REQ-007 data  in  N*W  source i beat occupies bits [i*W+W-1 : i*W].
REQ-008 last  in  N  per-source end-of-packet flag, qualified by req[i].
REQ-009 grant  in  N  combinational one-hot (or zero) grant from the round-robin arbiter.
REQ-010 ack  out  N  per-source ready; a beat transfers from source i when req[i] and ack[i] are both 1.
REQ-011 out_valid  out  1  registered output beat valid.
REQ-012 out_data  out  W  registered output beat data.
REQ-013 out_last  out  1  registered end-of-packet flag.
REQ-014 out_src  out  IW  registered index of the source of the beat.
REQ-015 out_ready  in  1  downstream ready; an output beat transfers when out_valid and out_ready are both 1.
REQ-016 locked  out  1  1 while in state LOCKED.
REQ-017 grant_err  out  1  sticky flag, set when grant has more than one bit set.

Function
REQ-018 space = !out_valid || out_ready; this gives full throughput with zero bubbles.
REQ-019 State IDLE: sel = index of the lowest set bit of grant; grant==0 means no selection.
REQ-020 State LOCKED: sel = lock_idx register; grant SHALL be ignored.
REQ-021 ack[i] = space && rst && selection valid && (i==sel); at most one ack bit SHALL be high in any cycle.
REQ-022 xfer = req[sel] && ack[sel]; on xfer, the output register loads data[sel], last[sel] and sel, and sets out_valid=1.
REQ-023 With no xfer, an output transfer clears out_valid; otherwise out_valid holds.
REQ-024 out_data, out_last and out_src SHALL hold their values while out_valid && !out_ready.
REQ-025 Latency: a beat accepted at edge k is presented on out_* after edge k (one-cycle latency).
REQ-026 Transition IDLE->LOCKED on xfer with last[sel]==0; lock_idx<=sel on the same edge.
REQ-027 Transition LOCKED->IDLE on xfer with last[sel]==1.
REQ-028 Single-beat packet: an IDLE xfer with last==1 SHALL remain in IDLE.
REQ-029 In LOCKED, req[lock_idx]==0 means no transfer and the lock is held indefinitely; other sources SHALL NOT receive ack.
REQ-030 A grant to a source with req low causes no transfer, no state change and no flag change.
REQ-031 grant_err is set on any cycle where popcount(grant)>1 and is cleared only by reset; selection still uses the lowest bit.
REQ-032 Simultaneous output transfer and xfer in the same cycle: the new beat replaces the old one and out_valid stays 1.

Reset
REQ-033 While rst==0, ack SHALL be all zeros (combinational).
REQ-034 At a rising edge with rst==0, the block SHALL enter: state IDLE, lock_idx=0, out_valid=0, out_data=0, out_last=0, out_src=0, locked=0, grant_err=0.
REQ-035 Reset mid-packet SHALL drop the lock and discard any pending output beat; the next packet is arbitrated from IDLE.

Verification
REQ-036 Single beat: N=5, req=00100, grant=00100, last[2]=1, data2=0xA5, out_ready=1 -> ack=00100; next cycle out_valid=1, out_data=0xA5, out_src=2, out_last=1, locked=0.
REQ-037 Packet lock: source 1 sends a 3-beat packet while req=00011 and grant toggles to 00001 -> ack stays 00010 for all 3 beats; locked=1 after beats 1 and 2; locked=0 after the last beat.
REQ-038 Backpressure: out_ready=0 with out_valid=1 -> ack=0 and out_* stable; when out_ready rises, the same cycle accepts a new beat and out_valid stays 1 (no bubble).
REQ-039 Illegal grant: grant=01010 with req=01010 -> source 1 is served and grant_err=1 stays set until rst=0.
REQ-040 Mid-packet reset: drive rst=0 for one edge during a 4-beat packet after beat 2 -> out_valid=0, locked=0; a different source's grant is then honoured immediately.
REQ-041 Round-robin stream: all 5 sources each send 2-beat packets continuously with the arbiter connected and out_ready=1 -> packets are never interleaved, out_src follows the order 0,0,1,1,2,2,..., and 100% throughput is achieved.
